// File: rtl/lfsr_pkg.sv
// Shared types and constants for the XNOR-feedback LFSR pattern checker.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int unsigned DEF_NUM_BITS = 25;
    localparam int unsigned DEF_TAP      = 22;
    localparam int unsigned MAX_BITS     = 64;

    // XNOR feedback never leaves the all-ones state, so it must not be loaded.
    localparam logic [MAX_BITS-1:0] LOCKUP_ONES = '1;

endpackage

// File: rtl/lfsr_step.sv
// One shift of the XNOR Fibonacci LFSR: predicted new LSB and the shifted state.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int unsigned NUM_BITS = DEF_NUM_BITS,
    parameter int unsigned TAP      = DEF_TAP
) (
    input  logic [NUM_BITS-1:0] state_i,
    output logic [NUM_BITS-1:0] next_o,
    output logic                pred_o
);

    assign pred_o = ~(state_i[NUM_BITS-1] ^ state_i[TAP-1]);
    assign next_o = {state_i[NUM_BITS-2:0], pred_o};

endmodule

// File: rtl/lfsr_checker.sv
// Serial PRBS checker: loads the shadow LFSR from the stream, verifies it,
// then flags and counts bit errors while locked.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned NUM_BITS = DEF_NUM_BITS,
    parameter int unsigned TAP      = DEF_TAP,
    parameter int unsigned LOCK_CNT = 32,
    parameter int unsigned LOSS_CNT = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [1:0]       o_state
);

    localparam int unsigned LOAD_W  = $clog2(NUM_BITS + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] s_q, s_d;
    logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic [NUM_BITS-1:0] step_next;
    logic [NUM_BITS-1:0] load_shift;
    logic                pred;
    logic                miss;

    lfsr_step #(
        .NUM_BITS (NUM_BITS),
        .TAP      (TAP)
    ) u_step (
        .state_i (s_q),
        .next_o  (step_next),
        .pred_o  (pred)
    );

    assign load_shift = {s_q[NUM_BITS-2:0], i_bit};
    assign miss       = (i_bit != pred);

    // Next state; once loaded the shadow free-runs on its own prediction.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        load_cnt_d  = load_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        locked_d    = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (i_valid) begin
                    s_d = load_shift;
                    if (load_cnt_q == LOAD_W'(NUM_BITS - 1)) begin
                        load_cnt_d = '0;
                        if (load_shift != LOCKUP_ONES[NUM_BITS-1:0]) begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        load_cnt_d = load_cnt_q + LOAD_W'(1);
                    end
                end
            end
            ST_VERIFY: begin
                if (i_valid) begin
                    s_d = step_next;
                    if (miss) begin
                        state_d     = ST_LOAD;
                        load_cnt_d  = '0;
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                    end else if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
                        state_d     = ST_LOCKED;
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + MATCH_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (i_valid) begin
                    s_d = step_next;
                    if (miss) begin
                        err_d = 1'b1;
                        if (miss_cnt_q == MISS_W'(LOSS_CNT - 1)) begin
                            state_d     = ST_LOAD;
                            load_cnt_d  = '0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d     = ST_LOAD;
                load_cnt_d  = '0;
                match_cnt_d = '0;
                miss_cnt_d  = '0;
            end
        endcase

        // Clear beats a coincident error; the pulse itself is unaffected.
        if (i_clear) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_LOAD;
            s_q         <= '0;
            load_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            load_cnt_q  <= load_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_locked  = locked_q;
    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;
    assign o_state   = 2'(state_q);

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker with an o_err scoreboard and an independent PRBS generator.
module tb_lfsr_checker;

    localparam int unsigned NB = 25;
    localparam int unsigned LK = 32;
    localparam int unsigned LS = 8;
    localparam int unsigned CW = 4;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_valid;
    logic          i_bit;
    logic          i_clear;
    logic          o_locked;
    logic          o_err;
    logic [CW-1:0] o_err_cnt;
    logic [1:0]    o_state;

    int unsigned vectors;
    int unsigned miscompares;
    int unsigned err_pulses;
    logic        exp_err_q[$];
    logic [24:0] g;

    lfsr_checker #(
        .NUM_BITS (NB),
        .TAP      (22),
        .LOCK_CNT (LK),
        .LOSS_CNT (LS),
        .CNT_W    (CW)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .i_bit     (i_bit),
        .i_clear   (i_clear),
        .o_locked  (o_locked),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt),
        .o_state   (o_state)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference generator: x^25+x^22+1 with XNOR feedback, new bit enters at LSB.
    task automatic gen_bit(output logic b);
        b = ~(g[24] ^ g[21]);
        g = {g[23:0], b};
    endtask

    // One clock of stimulus; the expected o_err is queued now and checked after the edge.
    task automatic cycle(input logic v, input logic b, input logic clr, input logic exp_e);
        logic e;
        i_valid = v;
        i_bit   = b;
        i_clear = clr;
        exp_err_q.push_back(exp_e);
        @(posedge i_clk);
        #1;
        e = exp_err_q.pop_front();
        chk("o_err", 32'(o_err), 32'(e));
        if (o_err) err_pulses++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_locked"}, 32'(o_locked), 32'd0);
        chk({tag, "_err"}, 32'(o_err), 32'd0);
        chk({tag, "_cnt"}, 32'(o_err_cnt), 32'd0);
        chk({tag, "_state"}, 32'(o_state), 32'd0);
    endtask

    task automatic mid_reset(input string tag);
        i_valid = 1'b0;
        i_clear = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        check_zero(tag);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic        b, r, miss, flip, v;
        int unsigned miss_run, nvalid, guard;

        vectors     = 0;
        miscompares = 0;
        err_pulses  = 0;
        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_bit       = 1'b0;
        i_clear     = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_zero("reset");
        i_rst_n = 1'b1;

        // Clean stream: lock after exactly 25+32 valid bits, then no errors.
        g = 25'h0ABCDEF;
        for (int n = 1; n <= 57; n++) begin
            gen_bit(b);
            cycle(1'b1, b, 1'b0, 1'b0);
            if (n == 24) chk("load_state_24", 32'(o_state), 32'd0);
            if (n == 25) chk("verify_state_25", 32'(o_state), 32'd1);
            if (n == 56) chk("locked_56", 32'(o_locked), 32'd0);
            if (n == 57) begin
                chk("locked_57", 32'(o_locked), 32'd1);
                chk("state_57", 32'(o_state), 32'd2);
            end
        end
        for (int n = 0; n < 10000; n++) begin
            gen_bit(b);
            cycle(1'b1, b, 1'b0, 1'b0);
        end
        chk("clean_cnt", 32'(o_err_cnt), 32'd0);
        chk("clean_locked", 32'(o_locked), 32'd1);

        // Three isolated flipped bits.
        err_pulses = 0;
        for (int n = 0; n < 600; n++) begin
            gen_bit(b);
            flip = (n == 100) || (n == 300) || (n == 500);
            cycle(1'b1, b ^ flip, 1'b0, flip);
        end
        chk("flip_pulses", err_pulses, 32'd3);
        chk("flip_cnt", 32'(o_err_cnt), 32'd3);
        chk("flip_locked", 32'(o_locked), 32'd1);

        // Saturation of the narrow counter, then clear coincident with an error.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clear_cnt", 32'(o_err_cnt), 32'd0);
        for (int n = 0; n < 240; n++) begin
            gen_bit(b);
            flip = ((n % 10) == 5);
            cycle(1'b1, b ^ flip, 1'b0, flip);
        end
        chk("sat_cnt", 32'(o_err_cnt), 32'd15);
        chk("sat_locked", 32'(o_locked), 32'd1);
        err_pulses = 0;
        gen_bit(b);
        cycle(1'b1, ~b, 1'b1, 1'b1);
        chk("clr_err_cnt", 32'(o_err_cnt), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_err_pulses", err_pulses, 32'd1);
        chk("clr_err_cnt2", 32'(o_err_cnt), 32'd0);

        // Random data while locked: lock drops on the 8th consecutive miss.
        miss_run = 0;
        guard    = 0;
        while (miss_run < LS && guard < 5000) begin
            gen_bit(b);
            r    = 1'($urandom_range(0, 1));
            miss = (r != b);
            miss_run = miss ? miss_run + 1 : 0;
            cycle(1'b1, r, 1'b0, miss);
            chk("rand_locked", 32'(o_locked), 32'(miss_run < LS));
            guard++;
        end
        chk("rand_loss_run", miss_run, LS);
        chk("rand_state", 32'(o_state), 32'd0);
        chk("rand_cnt_ge8", 32'(o_err_cnt >= CW'(8)), 32'd1);

        // Constant ones only ever loads the lock-up state.
        mid_reset("rst2");
        for (int n = 0; n < 200; n++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            chk("ones_state", 32'(o_state), 32'd0);
            chk("ones_locked", 32'(o_locked), 32'd0);
        end

        // Gapped valid: lock timing counts valid bits only.
        mid_reset("rst3");
        g      = 25'h0ABCDEF;
        nvalid = 0;
        guard  = 0;
        while (nvalid < 77 && guard < 2000) begin
            v = 1'($urandom_range(0, 1));
            b = 1'b0;
            if (v) gen_bit(b);
            cycle(v, b, 1'b0, 1'b0);
            if (v) nvalid++;
            chk("gap_locked", 32'(o_locked), 32'(nvalid >= 57));
            guard++;
        end
        chk("gap_nvalid", nvalid, 32'd77);
        chk("gap_state", 32'(o_state), 32'd2);
        mid_reset("rst_locked");
        for (int n = 1; n <= 57; n++) begin
            gen_bit(b);
            cycle(1'b1, b, 1'b0, 1'b0);
            if (n == 56) chk("reacq_56", 32'(o_locked), 32'd0);
            if (n == 57) chk("reacq_57", 32'(o_locked), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
